// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm ring controller: FSM state encoding,
// the snooze counter width and a helper for sizing tick timers.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2,
        ST_DONE   = 2'd3
    } alarm_state_t;

    // Width of the per-event snooze counter (MAX_SNOOZE is limited to 0..3).
    localparam int SNOOZE_USED_W = 2;

    // Bits needed to hold 0..max_val without wrapping (at least one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// debounced level. A debounced rising level produces a one-cycle press pulse;
// releases are filtered the same way but produce no pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_dly_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    // Synchronize, count consecutive samples that disagree with the accepted
    // level, flip the level on the DEBOUNCE_CYCLES-th one, and pulse on rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= btn;
            sync2_q     <= sync1_q;
            level_dly_q <= level_q;
            press_q     <= level_q & ~level_dly_q;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == LAST_CNT) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Turns the alarm-clock match level into a ring sequence: buzzer enable,
// blinking indicator, bounded snooze, stop and automatic silence on timeout.
// Timebase is the one-cycle tick enable from the frequency divider.
module alarm_ring_ctrl
    import alarm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES    = 500000,
    parameter int SNOOZE_TICKS       = 5,
    parameter int RING_TIMEOUT_TICKS = 30,
    parameter int MAX_SNOOZE         = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic                     alarm_match,
    input  logic                     btn_snooze,
    input  logic                     btn_stop,
    output logic                     ring,
    output logic                     blink,
    output logic                     snoozing,
    output logic [SNOOZE_USED_W-1:0] snooze_used,
    output alarm_state_t             state_dbg
);

    localparam int RW = cnt_width(RING_TIMEOUT_TICKS);
    localparam int SW = cnt_width(SNOOZE_TICKS);
    localparam logic [RW-1:0]            RING_LIMIT   = RW'(RING_TIMEOUT_TICKS);
    localparam logic [SW-1:0]            SNOOZE_LIMIT = SW'(SNOOZE_TICKS);
    localparam logic [SNOOZE_USED_W-1:0] SNOOZE_MAX   = SNOOZE_USED_W'(MAX_SNOOZE);

    logic snooze_press;
    logic stop_press;

    alarm_state_t             state_q;
    logic                     ring_q;
    logic                     blink_q;
    logic                     snoozing_q;
    logic [SNOOZE_USED_W-1:0] snooze_used_q;
    logic [RW-1:0]            ring_timer_q;
    logic [RW-1:0]            ring_timer_d;
    logic [SW-1:0]            snooze_timer_q;
    logic [SW-1:0]            snooze_timer_d;
    logic                     match_q;
    logic                     match_prev_q;
    logic                     match_rise;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_snooze_db (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_snooze),
        .press (snooze_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop_db (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_stop),
        .press (stop_press)
    );

    // Next timer values and the registered-match rise detector.
    always_comb begin
        ring_timer_d   = ring_timer_q + RW'(1);
        snooze_timer_d = snooze_timer_q + SW'(1);
        match_rise     = match_q & ~match_prev_q;
    end

    // Ring FSM with its timers and registered outputs. Reset loads the match
    // history as "high" so a match level still held after reset cannot be
    // taken for a new rise; it must fall and rise again.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            ring_q         <= 1'b0;
            blink_q        <= 1'b0;
            snoozing_q     <= 1'b0;
            snooze_used_q  <= '0;
            ring_timer_q   <= '0;
            snooze_timer_q <= '0;
            match_q        <= 1'b1;
            match_prev_q   <= 1'b1;
        end else begin
            match_q      <= alarm_match;
            match_prev_q <= match_q;
            case (state_q)
                ST_IDLE: begin
                    if (match_rise) begin
                        state_q        <= ST_RING;
                        ring_q         <= 1'b1;
                        blink_q        <= 1'b1;
                        ring_timer_q   <= '0;
                        snooze_timer_q <= '0;
                        snooze_used_q  <= '0;
                    end
                end
                ST_RING: begin
                    // Stop beats everything; a timeout tick beats snooze.
                    if (stop_press || (tick && ring_timer_d == RING_LIMIT)) begin
                        state_q <= ST_DONE;
                        ring_q  <= 1'b0;
                        blink_q <= 1'b0;
                    end else if (snooze_press && snooze_used_q < SNOOZE_MAX) begin
                        state_q        <= ST_SNOOZE;
                        ring_q         <= 1'b0;
                        blink_q        <= 1'b0;
                        snoozing_q     <= 1'b1;
                        snooze_used_q  <= snooze_used_q + SNOOZE_USED_W'(1);
                        snooze_timer_q <= '0;
                    end else if (tick) begin
                        ring_timer_q <= ring_timer_d;
                        blink_q      <= ~blink_q;
                    end
                end
                ST_SNOOZE: begin
                    if (stop_press) begin
                        state_q    <= ST_DONE;
                        snoozing_q <= 1'b0;
                    end else if (tick) begin
                        if (snooze_timer_d == SNOOZE_LIMIT) begin
                            state_q      <= ST_RING;
                            ring_q       <= 1'b1;
                            blink_q      <= 1'b1;
                            snoozing_q   <= 1'b0;
                            ring_timer_q <= '0;
                        end else begin
                            snooze_timer_q <= snooze_timer_d;
                        end
                    end
                end
                ST_DONE: begin
                    if (!match_q) begin
                        state_q       <= ST_IDLE;
                        snooze_used_q <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ring        = ring_q;
    assign blink       = blink_q;
    assign snoozing    = snoozing_q;
    assign snooze_used = snooze_used_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Bench for alarm_ring_ctrl: directed scenarios, a behavioural reference
// model stepped on every clock edge, a per-cycle output comparison and a set
// of hand-computed literal expectations.
module tb_alarm_ring_ctrl;
    import alarm_pkg::*;

    localparam int D    = 4;
    localparam int STK  = 3;
    localparam int RTK  = 5;
    localparam int MAXS = 2;

    localparam int M_IDLE = 0, M_RING = 1, M_SNOOZE = 2, M_DONE = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tick = 1'b0;
    logic         alarm_match = 1'b0;
    logic         btn_snooze = 1'b0;
    logic         btn_stop = 1'b0;
    logic         ring;
    logic         blink;
    logic         snoozing;
    logic [1:0]   snooze_used;
    alarm_state_t state_dbg;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;
    int tick_ctr = 0;

    alarm_ring_ctrl #(
        .DEBOUNCE_CYCLES    (D),
        .SNOOZE_TICKS       (STK),
        .RING_TIMEOUT_TICKS (RTK),
        .MAX_SNOOZE         (MAXS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .alarm_match (alarm_match),
        .btn_snooze  (btn_snooze),
        .btn_stop    (btn_stop),
        .ring        (ring),
        .blink       (blink),
        .snoozing    (snoozing),
        .snooze_used (snooze_used),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / timebase ----------------
    initial forever #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            tick_ctr++;
            tick = (tick_ctr % 10 == 0);
        end
    end

    // ---------------- reference model ----------------
    // Buttons: raw sample history; a level is accepted once the last D
    // synchronized samples (raw delayed by two edges) all disagree with it.
    // The FSM sees the press two edges after the debounced level rises.
    bit hist_sn[$];
    bit hist_st[$];
    bit db_sn, db_st;
    bit rsn1, rsn2, rst1, rst2;
    bit am1, am2;
    int m_mode, m_rticks, m_sticks, m_used;

    function automatic bit window_flips(input bit h[$], input bit lvl);
        for (int i = 0; i < D; i++)
            if (h[h.size() - 2 - i] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        bit p_sn, p_st, rose, rise, lvl;
        if (rst) begin
            hist_sn.delete();
            hist_st.delete();
            for (int i = 0; i < D + 2; i++) begin
                hist_sn.push_back(1'b0);
                hist_st.push_back(1'b0);
            end
            db_sn = 0; db_st = 0;
            rsn1 = 0; rsn2 = 0; rst1 = 0; rst2 = 0;
            am1 = 1; am2 = 1;
            m_mode = M_IDLE; m_rticks = 0; m_sticks = 0; m_used = 0;
        end else begin
            p_sn = rsn2;
            p_st = rst2;
            rose = 0;
            if (window_flips(hist_sn, db_sn)) begin db_sn = !db_sn; rose = db_sn; end
            rsn2 = rsn1; rsn1 = rose;
            rose = 0;
            if (window_flips(hist_st, db_st)) begin db_st = !db_st; rose = db_st; end
            rst2 = rst1; rst1 = rose;
            hist_sn.push_back(btn_snooze);
            hist_st.push_back(btn_stop);
            if (hist_sn.size() > D + 4) void'(hist_sn.pop_front());
            if (hist_st.size() > D + 4) void'(hist_st.pop_front());
            rise = am1 && !am2;
            lvl  = am1;
            am2  = am1;
            am1  = alarm_match;
            case (m_mode)
                M_IDLE: if (rise) begin
                    m_mode = M_RING; m_rticks = 0; m_sticks = 0; m_used = 0;
                end
                M_RING: begin
                    if (p_st) m_mode = M_DONE;
                    else if (tick && m_rticks + 1 >= RTK) m_mode = M_DONE;
                    else if (p_sn && m_used < MAXS) begin
                        m_mode = M_SNOOZE; m_used++; m_sticks = 0;
                    end else if (tick) m_rticks++;
                end
                M_SNOOZE: begin
                    if (p_st) m_mode = M_DONE;
                    else if (tick) begin
                        m_sticks++;
                        if (m_sticks >= STK) begin m_mode = M_RING; m_rticks = 0; end
                    end
                end
                default: if (!lvl) begin m_mode = M_IDLE; m_used = 0; end
            endcase
        end
    endtask

    function automatic logic [4:0] model_outputs();
        logic r, b, s;
        r = (m_mode == M_RING);
        b = r && (m_rticks % 2 == 0);
        s = (m_mode == M_SNOOZE);
        return {r, b, s, 2'(m_used)};
    endfunction

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- scoreboard ----------------
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            n_cmp++;
            if ({ring, blink, snoozing, snooze_used} !== model_outputs()) begin
                n_bad++;
                $display("FAIL cycle_cmp t=%0t: got ring,blink,snz,used=%b expected %b",
                         $time, {ring, blink, snoozing, snooze_used}, model_outputs());
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        int seen = 0;
        int budget = 0;
        while (seen < n && budget < 500) begin
            @(posedge clk);
            budget++;
            if (tick) seen++;
        end
        #1;
        if (seen < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_ticks: got %0d ticks expected %0d", seen, n);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        check("rst_ring", 8'(ring), 8'd0);
        check("rst_blink", 8'(blink), 8'd0);
        check("rst_snoozing", 8'(snoozing), 8'd0);
        check("rst_used", 8'(snooze_used), 8'd0);
        @(negedge clk); rst = 1'b0;

        // 1: ring, blink toggling, timeout after the 5th tick, DONE until match falls
        @(negedge clk); alarm_match = 1'b1;
        edges(1); check("t1_ring_not_yet", 8'(ring), 8'd0);
        edges(1); check("t1_ring_on", 8'(ring), 8'd1);
        check("t1_blink_entry", 8'(blink), 8'd1);
        wait_ticks(1); check("t1_blink_tick1", 8'(blink), 8'd0);
        wait_ticks(3); check("t1_ring_tick4", 8'(ring), 8'd1);
        check("t1_blink_tick4", 8'(blink), 8'd1);
        wait_ticks(1); check("t1_ring_timeout", 8'(ring), 8'd0);
        check("t1_state_done", 8'(state_dbg), 8'(ST_DONE));
        edges(15); check("t1_done_held", 8'(state_dbg), 8'(ST_DONE));
        @(negedge clk); alarm_match = 1'b0;
        edges(2); check("t1_idle", 8'(state_dbg), 8'(ST_IDLE));

        // 2: snooze press latency and return to ring after 3 ticks
        @(negedge clk); alarm_match = 1'b1;
        edges(2); check("t2_ring_on", 8'(ring), 8'd1);
        @(negedge clk); btn_snooze = 1'b1;
        edges(7); check("t2_snz_e6", 8'(snoozing), 8'd0);
        edges(1); check("t2_snz_e7", 8'(snoozing), 8'd1);
        check("t2_ring_off", 8'(ring), 8'd0);
        check("t2_used1", 8'(snooze_used), 8'd1);
        @(negedge clk); btn_snooze = 1'b0;
        wait_ticks(2); check("t2_still_snz", 8'(snoozing), 8'd1);
        wait_ticks(1); check("t2_ring_back", 8'(ring), 8'd1);
        check("t2_blink_back", 8'(blink), 8'd1);

        // 3: second snooze accepted, third ignored
        @(negedge clk); btn_snooze = 1'b1;
        edges(8); check("t3_used2", 8'(snooze_used), 8'd2);
        @(negedge clk); btn_snooze = 1'b0;
        wait_ticks(3); check("t3_ring_back", 8'(ring), 8'd1);
        @(negedge clk); btn_snooze = 1'b1;
        edges(8); check("t3_third_ignored", 8'(ring), 8'd1);
        check("t3_no_snz", 8'(snoozing), 8'd0);
        check("t3_used_sat", 8'(snooze_used), 8'd2);
        @(negedge clk); btn_snooze = 1'b0;
        edges(8);

        // 4: stop and snooze together -> DONE, count held, cleared in IDLE
        @(negedge clk); btn_snooze = 1'b1; btn_stop = 1'b1;
        edges(8); check("t4_state_done", 8'(state_dbg), 8'(ST_DONE));
        check("t4_ring", 8'(ring), 8'd0);
        check("t4_snz", 8'(snoozing), 8'd0);
        check("t4_used_held", 8'(snooze_used), 8'd2);
        @(negedge clk); btn_snooze = 1'b0; btn_stop = 1'b0; alarm_match = 1'b0;
        edges(3); check("t4_used_clr", 8'(snooze_used), 8'd0);
        check("t4_idle", 8'(state_dbg), 8'(ST_IDLE));
        edges(8);

        // 5: bounced stop button produces no press
        @(negedge clk); alarm_match = 1'b1;
        edges(2); check("t5_ring_on", 8'(ring), 8'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); btn_stop = (i % 4 < 2);
        end
        @(negedge clk); btn_stop = 1'b0;
        edges(10); check("t5_ring_kept", 8'(ring), 8'd1);
        check("t5_state_ring", 8'(state_dbg), 8'(ST_RING));

        // 6: reset in SNOOZE, held match does not retrigger
        @(negedge clk); btn_snooze = 1'b1;
        edges(8); check("t6_snz", 8'(snoozing), 8'd1);
        @(negedge clk); btn_snooze = 1'b0;
        edges(3);
        @(negedge clk); rst = 1'b1;
        edges(1); check("t6_rst_snz", 8'(snoozing), 8'd0);
        check("t6_rst_ring", 8'(ring), 8'd0);
        check("t6_rst_used", 8'(snooze_used), 8'd0);
        @(negedge clk); rst = 1'b0;
        edges(30); check("t6_no_retrigger", 8'(ring), 8'd0);
        check("t6_idle", 8'(state_dbg), 8'(ST_IDLE));
        @(negedge clk); alarm_match = 1'b0;
        edges(3);
        @(negedge clk); alarm_match = 1'b1;
        edges(2); check("t6_retrigger", 8'(ring), 8'd1);
        wait_ticks(5); check("t6_timeout", 8'(ring), 8'd0);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
